core_if: RTL

- Instruction fetch stage. Sits between the instruction memory port and core_id.
- Owns the fetch PC and issues word fetches over a request/grant/response handshake.
- Buffers returned words in a small FIFO and presents the head to decode as if_pc/if_instr.
- Honours decode stall (id_halt) and pipeline redirects (branch, call, ret, rfe, exception), discarding in-flight stale fetches.

---
 rtl/core_if.sv | 114 +++++++++++
 1 files changed

// File: rtl/core_if.sv
// rtl/core_if.sv - instruction fetch stage: owns the fetch PC, one fetch in flight, small buffer to decode
module core_if #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_halt,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        if_err
);

    localparam int          AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW         = AW + 1;
    localparam logic [5:0]  OPCODE_NOP = 6'h00;
    localparam logic [31:0] NOP_INSTR  = {OPCODE_NOP, 26'd0};

    logic [31:0]   r_pc_fetch;
    logic [31:0]   r_req_pc;
    logic          r_outstanding;
    logic          r_discard;
    logic          r_boot;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]   r_fifo_instr [FIFO_DEPTH];
    logic          r_fifo_err   [FIFO_DEPTH];

    logic          w_has_head;
    logic          w_pop;
    logic          w_grant;
    logic          w_resp;
    logic          w_push;
    logic [CW:0]   w_level;
    logic          w_unused_bits;

    assign w_unused_bits = ^redirect_pc[1:0];

    assign w_has_head = (r_count != '0);
    assign if_valid   = w_has_head && !rst;
    assign w_pop      = if_valid && !id_halt;

    // Occupancy after this cycle, counting the in-flight fetch as already holding a slot.
    assign w_level  = {1'b0, r_count} + (CW+1)'(r_outstanding) - (CW+1)'(w_pop);
    assign imem_req = !rst && !r_boot && !redirect_valid
                    && (!r_outstanding || imem_rvalid)
                    && (w_level < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = r_pc_fetch;

    assign w_grant = imem_req && imem_gnt;
    assign w_resp  = imem_rvalid && r_outstanding;
    assign w_push  = w_resp && !r_discard && !redirect_valid;

    assign if_pc    = rst ? RESET_PC : (w_has_head ? r_fifo_pc[r_rd_ptr] : r_pc_fetch);
    assign if_instr = if_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
    assign if_err   = if_valid && r_fifo_err[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_fetch    <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_boot        <= 1'b1;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_boot <= 1'b0;
            if (redirect_valid) begin
                // A fetch still in flight must be swallowed when it eventually returns.
                r_count       <= '0;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
                r_pc_fetch    <= {redirect_pc[31:2], 2'b00};
                r_outstanding <= r_outstanding && !imem_rvalid;
                r_discard     <= r_outstanding && !imem_rvalid;
            end else begin
                if (w_grant) begin
                    r_pc_fetch    <= r_pc_fetch + 32'd4;
                    r_req_pc      <= r_pc_fetch;
                    r_outstanding <= 1'b1;
                end else if (w_resp) begin
                    r_outstanding <= 1'b0;
                end
                if (w_resp) begin
                    r_discard <= 1'b0;
                end
                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]    <= r_req_pc;
                    r_fifo_instr[r_wr_ptr] <= imem_rdata;
                    r_fifo_err[r_wr_ptr]   <= imem_err;
                    r_wr_ptr               <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

endmodule
